// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the sequencer top and its return-address stack.
package pc_sequencer_pkg;

   localparam int          PC_W             = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; overflowing push overwrites the oldest entry.
// Top is combinational from the array; push/pop take effect at the clock edge.
// No backpressure: a push when full always succeeds by dropping the oldest entry.
module return_addr_stack
   import pc_sequencer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = PC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);

   localparam int            PW      = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW:0]   cnt;

   // ptr is the next write slot; once full it also points at the oldest entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (pop && !empty) begin
         ptr <= ptr - 1'b1;
         cnt <= cnt - 1'b1;
      end else if (push) begin
         mem[ptr] <= din;
         ptr      <= ptr + 1'b1;
         if (!full) cnt <= cnt + 1'b1;
      end
   end

   assign top   = mem[ptr - 1'b1];
   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_MAX);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter register, next-PC priority mux, RUN/HALT FSM and RAS control.
// next_pc is combinational and lands in pc one edge later; flags are registered.
// stall holds all state in RUN; HALT ignores everything except resume.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_offset,
   input  logic            jump,
   input  logic            call,
   input  logic            ret,
   input  logic [PC_W-1:0] jump_target,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] next_pc,
   output logic            halted,
   output logic            ras_overflow,
   output logic            ras_underflow
);

   state_t          state, state_nxt;
   logic [PC_W-1:0] inc, br_tgt, ras_top;
   logic            ras_push, ras_pop, ras_empty, ras_full;
   logic            ovf_nxt, unf_nxt;

   assign inc    = pc + 32'd1;
   assign br_tgt = inc + br_offset;

   // Only the winning control input may touch the stack or raise a flag
   always_comb begin
      next_pc   = pc;
      state_nxt = state;
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      ovf_nxt   = 1'b0;
      unf_nxt   = 1'b0;
      if (state == ST_HALT) begin
         if (resume) begin
            next_pc   = inc;
            state_nxt = ST_RUN;
         end
      end else if (!stall) begin
         if (halt_req) begin
            state_nxt = ST_HALT;
         end else if (ret) begin
            if (!ras_empty) begin
               next_pc = ras_top;
               ras_pop = 1'b1;
            end else begin
               next_pc = inc;
               unf_nxt = 1'b1;
            end
         end else if (call) begin
            next_pc  = jump_target;
            ras_push = 1'b1;
            ovf_nxt  = ras_full;
         end else if (jump) begin
            next_pc = jump_target;
         end else if (br_taken) begin
            next_pc = br_tgt;
         end else begin
            next_pc = inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= RESET_PC;
         state         <= ST_RUN;
         halted        <= 1'b0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         pc            <= next_pc;
         state         <= state_nxt;
         halted        <= (state_nxt == ST_HALT);
         ras_overflow  <= ovf_nxt;
         ras_underflow <= unf_nxt;
      end
   end

   return_addr_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (inc),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues the expected
// post-edge state for every driven cycle, which is popped and compared after the edge.
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h10;
   localparam int          DEPTH  = 4;

   typedef struct {
      logic [31:0] pc;
      logic        halted;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic        clk, rst, stall, halt_req, resume, br_taken, jump, call, ret;
   logic [31:0] br_offset, jump_target, pc, next_pc;
   logic        halted, ras_overflow, ras_underflow;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        exp_q[$];
   logic [31:0] m_ras[$];
   logic [31:0] m_pc;
   logic        m_halt;

   pc_sequencer #(
      .RESET_PC  (RST_PC),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .halt_req      (halt_req),
      .resume        (resume),
      .br_taken      (br_taken),
      .br_offset     (br_offset),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .jump_target   (jump_target),
      .pc            (pc),
      .next_pc       (next_pc),
      .halted        (halted),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc   = RST_PC;
      m_halt = 1'b0;
      m_ras.delete();
      exp_q.delete();
   endtask

   // One cycle: drive at negedge, predict, check next_pc, then check state after the edge
   task automatic step(input logic st, input logic hr, input logic rs, input logic bt,
                       input logic [31:0] off, input logic j, input logic c, input logic r,
                       input logic [31:0] tgt);
      exp_t        e;
      logic [31:0] npc;
      @(negedge clk);
      stall = st; halt_req = hr; resume = rs; br_taken = bt;
      br_offset = off; jump = j; call = c; ret = r; jump_target = tgt;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (m_halt) begin
         if (rs) begin
            npc    = m_pc + 32'd1;
            m_halt = 1'b0;
         end else begin
            npc = m_pc;
         end
      end else if (st) begin
         npc = m_pc;
      end else if (hr) begin
         npc    = m_pc;
         m_halt = 1'b1;
      end else if (r) begin
         if (m_ras.size() > 0) begin
            npc = m_ras.pop_back();
         end else begin
            npc   = m_pc + 32'd1;
            e.unf = 1'b1;
         end
      end else if (c) begin
         if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            e.ovf = 1'b1;
         end
         m_ras.push_back(m_pc + 32'd1);
         npc = tgt;
      end else if (j) begin
         npc = tgt;
      end else if (bt) begin
         npc = m_pc + 32'd1 + off;
      end else begin
         npc = m_pc + 32'd1;
      end
      m_pc     = npc;
      e.pc     = npc;
      e.halted = m_halt;
      exp_q.push_back(e);
      #1 chk("next_pc", next_pc, npc);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("pc", pc, e.pc);
         chk("halted", {31'd0, halted}, {31'd0, e.halted});
         chk("ras_overflow", {31'd0, ras_overflow}, {31'd0, e.ovf});
         chk("ras_underflow", {31'd0, ras_underflow}, {31'd0, e.unf});
      end
   endtask

   task automatic idle();                     step(0,0,0,0,0,0,0,0,0);   endtask
   task automatic do_jump(input logic [31:0] t); step(0,0,0,0,0,1,0,0,t); endtask
   task automatic do_call(input logic [31:0] t); step(0,0,0,0,0,0,1,0,t); endtask
   task automatic do_ret();                   step(0,0,0,0,0,0,0,1,0);   endtask

   // Assert reset between edges; pc must return to RESET_PC without waiting for a clock
   task automatic mid_reset();
      #3 rst = 1'b1;
      #1;
      chk("async_rst_pc", pc, RST_PC);
      chk("async_rst_halted", {31'd0, halted}, 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall = 0; halt_req = 0; resume = 0; br_taken = 0;
      br_offset = 0; jump = 0; call = 0; ret = 0; jump_target = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_pc", pc, RST_PC);
      chk("reset_halted", {31'd0, halted}, 32'd0);
      chk("reset_ovf", {31'd0, ras_overflow}, 32'd0);
      chk("reset_unf", {31'd0, ras_underflow}, 32'd0);

      repeat (3) idle();
      mid_reset();

      // Negative branch offset and 32-bit wrap
      do_jump(32'd5);
      step(0,0,0,1,-32'sd3,0,0,0,0);
      do_jump(32'hFFFF_FFFF);
      idle();

      // Stall holds pc and swallows a jump
      step(1,0,0,0,0,1,0,0,32'h1234);
      step(1,0,0,0,0,1,0,0,32'h1234);

      // Nested calls, unwinding returns, then an empty-stack return
      do_jump(32'd7);
      do_call(32'd100);
      do_call(32'd200);
      do_call(32'd300);
      repeat (3) do_ret();
      do_ret();
      idle();

      // Overflow on the fifth call, four newest addresses return, fifth ret underflows
      for (int i = 1; i <= 5; i++) do_call(32'd1000 * i);
      repeat (5) do_ret();

      // HALT ignores branches, jumps, stall and halt_req; resume wins
      do_jump(32'd20);
      step(0,1,0,0,0,0,0,0,0);
      step(0,0,0,1,32'd5,0,0,0,0);
      step(0,0,0,0,0,1,0,0,32'd77);
      step(1,0,0,0,0,1,0,0,32'd77);
      step(0,1,0,0,0,0,0,0,0);
      step(0,1,1,0,0,0,0,0,0);
      idle();

      // call+ret+jump: ret wins, no push, one entry consumed
      do_jump(32'd49);
      do_call(32'd500);
      step(0,0,0,0,0,1,1,1,32'd999);
      do_ret();

      // Reset discards stack contents
      do_call(32'd600);
      mid_reset();
      do_ret();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
